// File: rtl/prog_loader_pkg.sv
// loader_defs: shared state encoding and sizing constants for the program loader.
// The optional trailing-checksum stage (CHK state) exists only when
// LOADER_CHECKSUM_EN is defined.
package loader_defs;

    localparam int ADDR_W    = 10;
    localparam int INSTR_W   = 16;
    localparam int MAX_WORDS = 1024;
    // Word counter must hold MAX_WORDS itself, so one bit wider than the address.
    localparam int CNT_W     = 11;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DAT_HI = 3'd2,
        ST_DAT_LO = 3'd3,
        ST_WR     = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK    = 3'd5,
`endif
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // States in which the loader is willing to take a stream byte.
    function automatic logic takes_byte(input state_t s);
        case (s)
            ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and instruction-memory write bus of the loader.
// master = stream source / memory side, slave = the loader itself.
interface prog_loader_if;
    import loader_defs::*;

    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: holds the high byte of a word and, one cycle after the
// low byte is taken, presents the full 16-bit word with a single-cycle strobe.
module loader_word_assembler
    import loader_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               hi_load,
    input  logic               lo_load,
    input  logic [7:0]         byte_data,
    output logic               we,
    output logic [INSTR_W-1:0] wdata
);

    logic [7:0]         hi_reg;
    logic               we_reg;
    logic [INSTR_W-1:0] wdata_reg;

    // Latch the high byte, then register {hi, lo} and the strobe on the low byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg    <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
        end else begin
            we_reg <= lo_load;
            if (hi_load) begin
                hi_reg <= byte_data;
            end
            if (lo_load) begin
                wdata_reg <= {hi_reg, byte_data};
            end
        end
    end

    assign we    = we_reg;
    assign wdata = wdata_reg;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed byte stream and writes it word by word
// into instruction memory while holding the CPU in reset.
// Build option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module prog_loader
    import loader_defs::*;
(
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus,
    input  logic          load_req,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t            state_reg, state_next;
    logic [7:0]        len_hi_reg, len_hi_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_reg, chk_next;
`endif

    logic              ready;
    logic              accept;
    logic              hi_load;
    logic              lo_load;
    logic              we;
    logic [INSTR_W-1:0] wdata;
    logic [15:0]       len_word;

    assign ready    = takes_byte(state_reg);
    assign accept   = bus.byte_valid & ready;
    assign len_word = {len_hi_reg, bus.byte_data};

    // State and datapath registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_LEN_HI;
            len_hi_reg <= '0;
            count_reg  <= '0;
            addr_reg   <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            len_hi_reg <= len_hi_next;
            count_reg  <= count_next;
            addr_reg   <= addr_next;
`ifdef LOADER_CHECKSUM_EN
            chk_reg    <= chk_next;
`endif
        end
    end

    // Next-state and datapath updates; moves happen only on accepted bytes,
    // except the write cycle and the restart from a final state.
    always_comb begin
        state_next  = state_reg;
        len_hi_next = len_hi_reg;
        count_next  = count_reg;
        addr_next   = addr_reg;
        hi_load     = 1'b0;
        lo_load     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_next    = chk_reg;
`endif
        case (state_reg)
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_next = bus.byte_data;
                    state_next  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_word == 16'd0 || len_word > MAX_LEN) begin
                        state_next = ST_ERR;
                    end else begin
                        count_next = len_word[CNT_W-1:0];
                        addr_next  = '0;
                        state_next = ST_DAT_HI;
                    end
                end
            end
            ST_DAT_HI: begin
                if (accept) begin
                    hi_load    = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    chk_next   = chk_reg ^ bus.byte_data;
`endif
                    state_next = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                if (accept) begin
                    lo_load    = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    chk_next   = chk_reg ^ bus.byte_data;
`endif
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    // Last word: address is left on it so it can never wrap.
`ifdef LOADER_CHECKSUM_EN
                    state_next = ST_CHK;
`else
                    state_next = ST_DONE;
`endif
                end else begin
                    addr_next  = addr_reg + ADDR_W'(1);
                    state_next = ST_DAT_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_next = (bus.byte_data == chk_reg) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (load_req) begin
                    state_next = ST_LEN_HI;
                    addr_next  = '0;
                    count_next = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_next   = '0;
`endif
                end
            end
            default: begin
                state_next = ST_LEN_HI;
            end
        endcase
    end

    loader_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .hi_load   (hi_load),
        .lo_load   (lo_load),
        .byte_data (bus.byte_data),
        .we        (we),
        .wdata     (wdata)
    );

    assign bus.byte_ready = ready;
    assign bus.imem_we    = we;
    assign bus.imem_addr  = addr_reg;
    assign bus.imem_wdata = wdata;
    assign cpu_reset      = (state_reg != ST_DONE);
    assign done           = (state_reg == ST_DONE);
    assign error          = (state_reg == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed streams into prog_loader; expected memory writes are
// queued as bytes are issued and a negedge monitor checks each imem_we against them.
// Honours LOADER_CHECKSUM_EN by appending the XOR byte to generated streams.
module tb_prog_loader;
    import loader_defs::*;

    logic clk = 1'b0;
    logic reset;
    logic load_req;
    logic cpu_reset;
    logic done;
    logic error;

    prog_loader_if bus();

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .load_req  (load_req),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W+INSTR_W-1:0] exp_q[$];
    logic [ADDR_W+INSTR_W-1:0] mon_e;
    logic [15:0]               img[$];

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            n_tests++;
            if (done || error) begin
                n_fail++;
                $display("FAIL write_in_final: we=1 with done=%0b error=%0b, required we=0", done, error);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%0d data=%h, required no write", bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.imem_addr, bus.imem_wdata} !== mon_e) begin
                    n_fail++;
                    $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                             bus.imem_addr, bus.imem_wdata, mon_e[INSTR_W+:ADDR_W], mon_e[INSTR_W-1:0]);
                end else begin
                    $display("[TB] write addr=%0d data=%h ok", bus.imem_addr, bus.imem_wdata);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("[TB] %s = %0h ok", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL ready_timeout: byte %h not accepted, required ready within 200 cycles", b);
                break;
            end
        end
        @(posedge clk);
        #1 bus.byte_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int max_gap);
        if (max_gap == 0) return 0;
        return int'($urandom_range(0, max_gap));
    endfunction

    // Sends length + img[] words (+ checksum when enabled), queueing expected writes.
    task automatic send_image(input logic [15:0] len, input int max_gap);
        logic [7:0] x;
        x = 8'h00;
        send_byte(len[15:8], pick_gap(max_gap));
        send_byte(len[7:0], pick_gap(max_gap));
        foreach (img[i]) begin
            exp_q.push_back({ADDR_W'(i), img[i]});
            x = x ^ img[i][15:8] ^ img[i][7:0];
            send_byte(img[i][15:8], pick_gap(max_gap));
            send_byte(img[i][7:0], pick_gap(max_gap));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, pick_gap(max_gap));
`endif
    endtask

    task automatic wait_end(input string name, input logic exp_done, input logic exp_error);
        int k;
        k = 0;
        while (!(done || error) && k < 10000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_error"}, 32'(error), 32'(exp_error));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        check({name, "_ready"}, 32'(bus.byte_ready), 32'(1'b0));
        check({name, "_writes_left"}, 32'(exp_q.size()), 32'(0));
    endtask

    task automatic restart(input string name);
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check({name, "_ready"}, 32'(bus.byte_ready), 32'(1'b1));
        check({name, "_done"}, 32'(done), 32'(1'b0));
        check({name, "_error"}, 32'(error), 32'(1'b0));
        img.delete();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        load_req       = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(bus.byte_ready), 32'(1'b1));
        check("rst_cpu_reset", 32'(cpu_reset), 32'(1'b1));
        check("rst_done", 32'(done), 32'(1'b0));
        check("rst_error", 32'(error), 32'(1'b0));
        check("rst_we", 32'(bus.imem_we), 32'(1'b0));
        check("rst_addr", 32'(bus.imem_addr), 32'(0));
        check("rst_wdata", 32'(bus.imem_wdata), 32'(0));

        // Two-word image: 0x1234@0, 0xABCD@1
        img = '{16'h1234, 16'hABCD};
        send_image(16'h0002, 0);
        wait_end("two_words", 1'b1, 1'b0);

        // Zero length -> ERR, then restart and load a valid image
        restart("restart1");
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_end("len_zero", 1'b0, 1'b1);
        restart("restart2");
        img = '{16'hBEEF};
        send_image(16'h0001, 0);
        wait_end("after_err", 1'b1, 1'b0);

        // load_req while waiting in DAT_LO is ignored
        restart("restart3");
        exp_q.push_back({ADDR_W'(0), 16'h0102});
        exp_q.push_back({ADDR_W'(1), 16'h0304});
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check("ign_req_ready", 32'(bus.byte_ready), 32'(1'b1));
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h04, 0);
`endif
        wait_end("ign_req", 1'b1, 1'b0);

        // Randomly stalled byte_valid gives the same writes
        restart("restart4");
        img = '{16'h0A0B, 16'hC0DE, 16'h7F80};
        send_image(16'h0003, 3);
        wait_end("stalled", 1'b1, 1'b0);

        // Reset after a DAT_HI byte discards the partial word
        restart("restart5");
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h55, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ready", 32'(bus.byte_ready), 32'(1'b1));
        check("midrst_addr", 32'(bus.imem_addr), 32'(0));
        check("midrst_we", 32'(bus.imem_we), 32'(1'b0));
        check("midrst_wdata", 32'(bus.imem_wdata), 32'(0));
        check("midrst_cpu_reset", 32'(cpu_reset), 32'(1'b1));
        img = '{16'h6677};
        send_image(16'h0001, 0);
        wait_end("after_midrst", 1'b1, 1'b0);

        // Maximum image: 1024 words, value = index; last write 0x03FF@1023
        restart("restart6");
        for (int i = 0; i < MAX_WORDS; i++) img.push_back(16'(i));
        send_image(16'h0400, 0);
        wait_end("max_len", 1'b1, 1'b0);

        // Length 1025 -> ERR
        restart("restart7");
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        wait_end("len_1025", 1'b0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum 0x12^0x34 = 0x26 matches; 0x27 does not
        restart("restart8");
        exp_q.push_back({ADDR_W'(0), 16'h1234});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h26, 0);
        wait_end("chk_ok", 1'b1, 1'b0);
        restart("restart9");
        exp_q.push_back({ADDR_W'(0), 16'h1234});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h27, 0);
        wait_end("chk_bad", 1'b0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have clock and reset: clk input 1, the single clock; one clock domain; reset is synchronous and active-high.
REQ-002 SHALL have reset input 1: synchronous, active-high, sampled on posedge clk.
REQ-003 SHALL have byte_valid input 1: the source presents byte_data.
REQ-004 SHALL have byte_data input 8: the stream byte.
REQ-005 SHALL have byte_ready output 1: the loader accepts a byte; a transfer occurs when byte_valid & byte_ready at posedge clk.
REQ-006 SHALL have load_req input 1: a one-cycle pulse that restarts loading from DONE or ERR.
REQ-007 SHALL have imem_we output 1: instruction-memory write strobe.
REQ-008 SHALL have imem_addr output 10: the instruction word address.
REQ-009 SHALL have imem_wdata output 16: the instruction word.
REQ-010 SHALL have cpu_reset output 1: holds the CPU pipeline in reset while loading.
REQ-011 SHALL have done output 1: the load completed successfully.
REQ-012 SHALL have error output 1: the load was aborted.

Function
REQ-013 Stream format SHALL be: length high byte, length low byte (16-bit N), then N words, each sent high byte first.
REQ-014 FSM states SHALL be LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK (macro only), DONE, ERR; state transitions occur only on an accepted byte, except WR handling per REQ-017.
REQ-015 In LEN_LO, a length N=0 or N>1024 SHALL go to ERR; otherwise the loader goes to DAT_HI with word counter = N and addr = 0.
REQ-016 byte_ready SHALL be 1 in LEN_HI/LEN_LO/DAT_HI/DAT_LO/CHK, and 0 in DONE/ERR and during the imem_we cycle.
REQ-017 An accepted DAT_LO byte SHALL produce, on the next cycle, imem_we=1 for exactly one cycle, with imem_wdata={hi,lo} and imem_addr = current address; the address then increments and the counter decrements.
REQ-018 After the write of the last word (counter reaches 0), the loader SHALL go to CHK if the macro is defined, else to DONE.
REQ-019 imem_addr SHALL never wrap: the maximum written address is 1023 (N=1024).
REQ-020 cpu_reset SHALL be 1 in every state except DONE; done=1 only in DONE; error=1 only in ERR.
REQ-021 load_req in DONE or ERR SHALL go to LEN_HI next cycle, clearing addr, counter, done and error; load_req in any other state SHALL be ignored.
REQ-022 byte_valid=0 SHALL stall the FSM indefinitely with no state change and no timeout.
REQ-023 imem_we SHALL be 0 whenever the state is DONE or ERR.

Reset
REQ-024 reset SHALL force next cycle: state LEN_HI, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, byte_ready=1, counter=0, checksum=0.
REQ-025 reset mid-load SHALL discard any partial word; no imem_we SHALL issue in the cycle after reset.
REQ-026 reset SHALL take priority over load_req and byte transfers in the same cycle.

Configuration
REQ-027 Macro LOADER_CHECKSUM_EN defined: the loader SHALL XOR all payload data bytes (not length bytes) into an 8-bit accumulator; one trailing byte is accepted in CHK; a match goes to DONE, a mismatch goes to ERR.
REQ-028 LOADER_CHECKSUM_EN undefined: the loader SHALL have no CHK state and no accumulator; the last word goes directly to DONE.

Structure
REQ-029 A shared package loader_defs SHALL hold the state encoding, ADDR_W=10, INSTR_W=16, MAX_WORDS=1024.
REQ-030 One sub-module, loader_word_assembler, SHALL latch the high byte and form the 16-bit word plus the write strobe; the FSM, counters and checksum stay in prog_loader.

Verification
REQ-031 The bench SHALL cover: stream 00 02 12 34 AB CD (no macro) -> writes 0x1234@0 then 0xABCD@1; done=1 and cpu_reset=0 after the second write.
REQ-032 The bench SHALL cover: length 00 00 -> error=1, byte_ready=0, no imem_we; load_req then a valid stream -> done=1.
REQ-033 The bench SHALL cover: length 04 00 with 1024 words of value=index -> last write is addr 1023, data 0x03FF; length 04 01 -> ERR.
REQ-034 The bench SHALL cover: with the macro, 00 01 12 34 26 -> DONE; 00 01 12 34 27 -> ERR, cpu_reset stays 1.
REQ-035 The bench SHALL cover: byte_valid toggled randomly mid-stream -> same writes as the contiguous stream; reset after a DAT_HI byte -> LEN_HI, addr 0, no write.
REQ-036 The bench SHALL cover: load_req asserted during DAT_LO -> ignored; load completes normally.
